// File: rtl/sonic_cmd_sequencer_if.sv
// rtl/sonic_cmd_sequencer_if.sv - engine request/ack/done and response-write bus of the SoNIC command sequencer
interface sonic_cmd_sequencer_if #(
  parameter int NUM_ENG = 4
);
  logic [NUM_ENG-1:0] eng_req;
  logic [7:0]         eng_opcode;
  logic [31:0]        eng_param0;
  logic [31:0]        eng_param1;
  logic [31:0]        eng_param2;
  logic [NUM_ENG-1:0] eng_ack;
  logic [NUM_ENG-1:0] eng_done;
  logic [NUM_ENG-1:0] eng_err;
  logic               resp_req;
  logic [63:0]        resp_addr;
  logic               resp_3dw;
  logic [31:0]        resp_data;
  logic               resp_ack;

  modport master (
    output eng_req, eng_opcode, eng_param0, eng_param1, eng_param2,
    input  eng_ack, eng_done, eng_err,
    output resp_req, resp_addr, resp_3dw, resp_data,
    input  resp_ack
  );

  modport slave (
    input  eng_req, eng_opcode, eng_param0, eng_param1, eng_param2,
    output eng_ack, eng_done, eng_err,
    input  resp_req, resp_addr, resp_3dw, resp_data,
    output resp_ack
  );
endinterface

// File: rtl/sonic_cmd_sequencer.sv
// rtl/sonic_cmd_sequencer.sv - one-deep command sequencer: engine dispatch, watchdog, status response
// Optional feature macro SONIC_CMD_RESP_EN: when defined, completions go through RESP and a host status write.
module sonic_cmd_sequencer #(
  parameter int NUM_ENG   = 4,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk_in,
  input  logic                 rstn,
  input  logic                 cmd_strobe,
  input  logic                 cmd_abort,
  input  logic [31:0]          cmd_type,
  input  logic [31:0]          cmd_param0,
  input  logic [31:0]          cmd_param1,
  input  logic [31:0]          cmd_param2,
  input  logic [63:0]          cmd_base_rc,
  input  logic                 cmd_3dw_rcadd,
  sonic_cmd_sequencer_if.master bus,
  output logic                 busy,
  output logic                 cmd_overrun,
  output logic [31:0]          last_status
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_DISPATCH  = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_RESP      = 2'd3;

  localparam logic [2:0] CODE_OK      = 3'd0;
  localparam logic [2:0] CODE_ENG_ERR = 3'd1;
  localparam logic [2:0] CODE_TIMEOUT = 3'd2;
  localparam logic [2:0] CODE_BAD_ENG = 3'd3;

  function automatic logic [NUM_ENG-1:0] onehot(input logic [3:0] idx);
    logic [NUM_ENG-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_ENG; i++) v[i] = (idx == 4'(i));
    return v;
  endfunction

  function automatic logic [31:0] status_word(input logic [7:0] seq, input logic [7:0] op,
                                              input logic ovr, input logic [2:0] code,
                                              input logic [3:0] idx);
    return {seq, op, 3'b000, ovr, 1'b0, code, 4'b0000, idx};
  endfunction

  logic [1:0]           state_q, state_n;
  logic [3:0]           idx_q, idx_n;
  logic [7:0]           opcode_q, opcode_n;
  logic [31:0]          param0_q, param0_n, param1_q, param1_n, param2_q, param2_n;
  logic [63:0]          addr_q, addr_n;
  logic                 f3_q, f3_n;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_n;
  logic [2:0]           code_q, code_n;
  logic [7:0]           seq_q, seq_n;
  logic                 ovr_q, ovr_n;
  logic                 overrun_q, overrun_n;
  logic [NUM_ENG-1:0]   eng_req_q, eng_req_n;
  logic                 resp_req_q, resp_req_n;
  logic [31:0]          resp_data_q, resp_data_n;
  logic [31:0]          last_status_q, last_status_n;
  logic                 busy_q, busy_n;

  logic [NUM_ENG-1:0] sel;
  logic               ack_hit, done_hit, err_hit, wd_sat, strobe_ok, finish;
  logic               unused_type_bits;

  assign unused_type_bits = ^{cmd_type[31:16], cmd_type[7:4]};

  // Only the selected engine's handshake bits matter; acks/dones elsewhere are ignored.
  assign sel       = onehot(idx_q);
  assign ack_hit   = |(bus.eng_ack & sel);
  assign done_hit  = |(bus.eng_done & sel);
  assign err_hit   = |(bus.eng_err & sel);
  assign wd_sat    = &wdog_q;
  assign strobe_ok = cmd_strobe && !cmd_abort;

  always_comb begin
    state_n       = state_q;
    idx_n         = idx_q;
    opcode_n      = opcode_q;
    param0_n      = param0_q;
    param1_n      = param1_q;
    param2_n      = param2_q;
    addr_n        = addr_q;
    f3_n          = f3_q;
    wdog_n        = wdog_q;
    code_n        = code_q;
    seq_n         = seq_q;
    ovr_n         = ovr_q;
    eng_req_n     = eng_req_q;
    resp_req_n    = resp_req_q;
    last_status_n = last_status_q;
    finish        = 1'b0;

    overrun_n = strobe_ok && (state_q != ST_IDLE);
    if (overrun_n) ovr_n = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (strobe_ok) begin
          idx_n    = cmd_type[3:0];
          opcode_n = cmd_type[15:8];
          param0_n = cmd_param0;
          param1_n = cmd_param1;
          param2_n = cmd_param2;
          addr_n   = cmd_base_rc;
          f3_n     = cmd_3dw_rcadd;
          wdog_n   = '0;
          if ({1'b0, cmd_type[3:0]} < 5'(NUM_ENG)) begin
            state_n   = ST_DISPATCH;
            eng_req_n = onehot(cmd_type[3:0]);
          end else begin
            code_n = CODE_BAD_ENG;
            finish = 1'b1;
          end
        end
      end
      ST_DISPATCH: begin
        wdog_n = wdog_q + TIMEOUT_W'(1);
        if (ack_hit) begin
          state_n   = ST_WAIT_DONE;
          eng_req_n = '0;
          wdog_n    = '0;
        end else if (wd_sat) begin
          eng_req_n = '0;
          code_n    = CODE_TIMEOUT;
          finish    = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        wdog_n = wdog_q + TIMEOUT_W'(1);
        if (done_hit) begin
          code_n = err_hit ? CODE_ENG_ERR : CODE_OK;
          finish = 1'b1;
        end else if (wd_sat) begin
          code_n = CODE_TIMEOUT;
          finish = 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.resp_ack) begin
          last_status_n = resp_data_q;
          seq_n         = seq_q + 8'd1;
          ovr_n         = overrun_n;
          resp_req_n    = 1'b0;
          state_n       = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (finish) begin
`ifdef SONIC_CMD_RESP_EN
      state_n    = ST_RESP;
      resp_req_n = 1'b1;
`else
      // Completion retires immediately: the word carries the pre-increment seq and the old sticky bit.
      state_n       = ST_IDLE;
      last_status_n = status_word(seq_q, opcode_n, ovr_q, code_n, idx_n);
      seq_n         = seq_q + 8'd1;
      ovr_n         = overrun_n;
`endif
    end

    if (cmd_abort) begin
      state_n       = ST_IDLE;
      eng_req_n     = '0;
      resp_req_n    = 1'b0;
      ovr_n         = 1'b0;
      overrun_n     = 1'b0;
      seq_n         = seq_q;
      last_status_n = last_status_q;
    end

    busy_n      = (state_n != ST_IDLE);
    resp_data_n = status_word(seq_n, opcode_n, ovr_n, code_n, idx_n);
  end

  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      opcode_q      <= '0;
      param0_q      <= '0;
      param1_q      <= '0;
      param2_q      <= '0;
      addr_q        <= '0;
      f3_q          <= 1'b0;
      wdog_q        <= '0;
      code_q        <= '0;
      seq_q         <= '0;
      ovr_q         <= 1'b0;
      overrun_q     <= 1'b0;
      eng_req_q     <= '0;
      resp_req_q    <= 1'b0;
      resp_data_q   <= '0;
      last_status_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_n;
      idx_q         <= idx_n;
      opcode_q      <= opcode_n;
      param0_q      <= param0_n;
      param1_q      <= param1_n;
      param2_q      <= param2_n;
      addr_q        <= addr_n;
      f3_q          <= f3_n;
      wdog_q        <= wdog_n;
      code_q        <= code_n;
      seq_q         <= seq_n;
      ovr_q         <= ovr_n;
      overrun_q     <= overrun_n;
      eng_req_q     <= eng_req_n;
      resp_req_q    <= resp_req_n;
      resp_data_q   <= resp_data_n;
      last_status_q <= last_status_n;
      busy_q        <= busy_n;
    end
  end

  assign bus.eng_req    = eng_req_q;
  assign bus.eng_opcode = opcode_q;
  assign bus.eng_param0 = param0_q;
  assign bus.eng_param1 = param1_q;
  assign bus.eng_param2 = param2_q;
  assign bus.resp_req   = resp_req_q;
  assign bus.resp_addr  = addr_q;
  assign bus.resp_3dw   = f3_q;
  assign bus.resp_data  = resp_data_q;
  assign busy           = busy_q;
  assign cmd_overrun    = overrun_q;
  assign last_status    = last_status_q;

endmodule
